// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the two-digit seven-segment scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_UNITS = 2'd0,
        S_GAP0  = 2'd1,
        S_TENS  = 2'd2,
        S_GAP1  = 2'd3
    } scan_state_e;

    // Active-high segment codes, bit order gfedcba
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-high seven-segment decode; non-BCD values show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed display driver: prescaled scan with gap phases,
// leading-zero suppression, blank and blink, all outputs registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 1000,
    parameter int BLINK_DIV    = 250,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tens_in,
    input  logic [3:0] units_in,
    input  logic       load,
    input  logic       blank,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam logic [6:0] SEG_IDLE = COMMON_ANODE ? ~SEG_OFF : SEG_OFF;
    localparam logic [1:0] AN_IDLE  = COMMON_ANODE ? 2'b11 : 2'b00;

    scan_state_e state_q;
    logic [15:0] cnt_q;
    logic [9:0]  bcnt_q;
    logic        blink_phase_q;
    logic        blank_q;
    logic [3:0]  tens_q, units_q;
    logic [6:0]  seg_q, seg_d, dec_seg;
    logic [1:0]  an_q, an_d;
    logic        err_q;
    logic        tick, bwrap;

    assign tick  = (cnt_q == 16'(CLK_DIV - 1));
    assign bwrap = (bcnt_q == 10'(BLINK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= tick ? '0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_UNITS;
        end else if (tick) begin
            case (state_q)
                S_UNITS: state_q <= S_GAP0;
                S_GAP0:  state_q <= S_TENS;
                S_TENS:  state_q <= S_GAP1;
                default: state_q <= S_UNITS;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q  <= '0;
            units_q <= '0;
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank;
            if (load) begin
                tens_q  <= tens_in;
                units_q <= units_in;
            end
        end
    end

    // Disabling blink clears the phase so the next enable starts visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q        <= '0;
            blink_phase_q <= 1'b0;
        end else if (!blink_en) begin
            bcnt_q        <= '0;
            blink_phase_q <= 1'b0;
        end else if (tick) begin
            if (bwrap) begin
                bcnt_q        <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                bcnt_q <= bcnt_q + 10'd1;
            end
        end
    end

    seg7_decode u_decode (
        .digit_i (state_q == S_TENS ? tens_q : units_q),
        .seg_o   (dec_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = 2'b00;
        if (!blank_q && !blink_phase_q) begin
            if (state_q == S_UNITS) begin
                seg_d = dec_seg;
                an_d  = 2'b01;
            end else if (state_q == S_TENS && tens_q != 4'd0) begin
                seg_d = dec_seg;
                an_d  = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_IDLE;
            an_q  <= AN_IDLE;
            err_q <= 1'b0;
        end else begin
            seg_q <= COMMON_ANODE ? ~seg_d : seg_d;
            an_q  <= COMMON_ANODE ? ~an_d : an_d;
            err_q <= (tens_q > 4'd9) || (units_q > 4'd9);
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count based reference model
// predicts every registered output; a monitor compares on the falling edge.
module tb_seg7_scan_driver;

    localparam int CD = 4;
    localparam int BD = 2;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tens_in = '0, units_in = '0;
    logic       load = 1'b0, blank = 1'b0, blink_en = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    // Reference model state: edges since reset, latched digits, ticks seen
    // while blinking, and blank as seen one edge ago.
    int         m_n;
    int         m_bt;
    logic [3:0] m_tens, m_units;
    logic       m_blank;
    logic [6:0] tbl [16];

    seg7_scan_driver #(.CLK_DIV(CD), .BLINK_DIV(BD), .COMMON_ANODE(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .tens_in  (tens_in),
        .units_in (units_in),
        .load     (load),
        .blank    (blank),
        .blink_en (blink_en),
        .seg      (seg),
        .an       (an),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_n = 0; m_bt = 0; m_tens = 0; m_units = 0; m_blank = 0;
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   phase;
        logic dark;
        logic [1:0] a;
        logic [6:0] s;
        phase = (m_n / CD) % 4;
        dark  = m_blank || (((m_bt / BD) % 2) == 1);
        a = 2'b00; s = 7'h00;
        if (!dark) begin
            if (phase == 0) begin
                a = 2'b01; s = tbl[m_units];
            end else if (phase == 2 && m_tens != 0) begin
                a = 2'b10; s = tbl[m_tens];
            end
        end
        e.an  = ~a;
        e.seg = ~s;
        e.err = (m_tens > 9) || (m_units > 9);
        return e;
    endfunction

    task automatic step();
        exp_t e;
        e = predict();
        @(posedge clk);
        q.push_back(e);
        if (!blink_en) m_bt = 0;
        else if ((m_n % CD) == CD - 1) m_bt++;
        m_n++;
        if (load) begin
            m_tens = tens_in; m_units = units_in;
        end
        m_blank = blank;
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(logic [3:0] t, logic [3:0] u);
        tens_in = t; units_in = u; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic check_idle(string name);
        n_cmp++;
        if (an !== 2'b11 || seg !== 7'h7F || err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: an=%b seg=%h err=%b, want an=11 seg=7f err=0", name, an, seg, err);
        end
    endtask

    // Monitor: one registered output per clock edge, checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (an !== e.an || seg !== e.seg || err !== e.err) begin
                    n_bad++;
                    $display("FAIL scan@%0t: an=%b seg=%h err=%b, want an=%b seg=%h err=%b",
                             $time, an, seg, err, e.an, e.seg, e.err);
                end
            end
        end
    end

    initial begin
        tbl[0] = 7'h3F; tbl[1] = 7'h06; tbl[2] = 7'h5B; tbl[3] = 7'h4F;
        tbl[4] = 7'h66; tbl[5] = 7'h6D; tbl[6] = 7'h7D; tbl[7] = 7'h07;
        tbl[8] = 7'h7F; tbl[9] = 7'h6F;
        for (int i = 10; i < 16; i++) tbl[i] = 7'h40;
        model_reset();

        #12;
        check_idle("reset_initial");
        @(posedge clk); #1;
        rst = 1'b0;

        run(3);
        do_load(4'd4, 4'd2);  run(18);
        do_load(4'd0, 4'd7);  run(16);
        do_load(4'd0, 4'd0);  run(16);
        do_load(4'd12, 4'd3); run(16);
        do_load(4'd1, 4'd3);  run(16);

        // load on the tick edge that enters TENS
        while ((m_n % 16) != 7) step();
        do_load(4'd9, 4'd9);  run(10);

        // asynchronous reset in the middle of TENS
        while ((m_n % 16) != 9) step();
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_idle("reset_mid_tens");
        q.delete();
        model_reset();
        @(posedge clk); #1;
        check_idle("reset_held");
        rst = 1'b0;
        run(8);

        do_load(4'd5, 4'd8);
        blink_en = 1'b1; run(20);
        blank = 1'b1;    run(3);
        blank = 1'b0;    run(20);
        blink_en = 1'b0; run(6);

        for (int i = 0; i < 2500; i++) begin
            load = ($urandom_range(0, 4) == 0);
            tens_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            units_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) blank = ~blank;
            if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
            step();
        end
        load = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expected outputs left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
